// File: rtl/uart_bit_sampler_if.sv
`default_nettype none
// ============================================================================
//  Module   : uart_bit_sampler_if
//  Purpose  : Signal bundle between the UART rx front end / receive FSM
//             (master) and the oversampled bit sampler (slave).
//  Revision : 1.0  initial release
// ============================================================================
interface uart_bit_sampler_if;
  logic baud_en;      // oversample strobe, one clk wide
  logic rx;           // synchronized serial line, idle high
  logic stop;         // receive FSM ends the frame
  logic active;       // sampler is tracking a frame
  logic center_tick;  // bit decision valid (one clk pulse)
  logic mid_sample;   // decided bit value, held between decisions
  logic false_start;  // start bit rejected (one clk pulse)
  logic noise;        // vote disagreement (one clk pulse)

  modport master (
    output baud_en, rx, stop,
    input  active, center_tick, mid_sample, false_start, noise
  );

  modport slave (
    input  baud_en, rx, stop,
    output active, center_tick, mid_sample, false_start, noise
  );
endinterface : uart_bit_sampler_if
`default_nettype wire

// File: rtl/uart_bit_sampler.sv
`default_nettype none
// ============================================================================
//  Module   : uart_bit_sampler
//  Purpose  : Oversampled bit-phase tracker for the UART receive path. Locks
//             phase on the start-bit falling edge, validates the start bit and
//             then emits one center_tick per bit with the sampled value.
//  Options  : UART_MAJORITY_VOTE_EN - 3-sample majority vote around the bit
//             centre with a noise flag; otherwise a single centre sample.
//  Revision : 1.0  initial release
// ============================================================================
module uart_bit_sampler #(
  parameter int OVERSAMPLE = 16
) (
  input  wire logic          clk,
  input  wire logic          rst,
  uart_bit_sampler_if.slave  bus
);

  localparam int CENTER = OVERSAMPLE / 2;
  localparam int PW     = $clog2(OVERSAMPLE);

  localparam logic [PW-1:0] c_PH_LAST = PW'(OVERSAMPLE - 1);
`ifdef UART_MAJORITY_VOTE_EN
  localparam logic [PW-1:0] c_PH_V0   = PW'(CENTER - 1);
  localparam logic [PW-1:0] c_PH_V1   = PW'(CENTER);
  localparam logic [PW-1:0] c_PH_DEC  = PW'(CENTER + 1);
`else
  localparam logic [PW-1:0] c_PH_DEC  = PW'(CENTER);
`endif

  generate
    if (OVERSAMPLE < 4) begin : g_bad_oversample
      $error("uart_bit_sampler: OVERSAMPLE must be >= 4");
    end
  endgenerate

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t        r_state;
  logic [PW-1:0] r_ph;
  logic          r_rx_prev;
  logic          r_start_pend;  // first decision of the frame is the start bit
  logic          r_active;
  logic          r_tick;
  logic          r_mid;
  logic          r_false;

  logic          w_edge;
  logic          w_result;

`ifdef UART_MAJORITY_VOTE_EN
  logic          r_v0;
  logic          r_v1;
  logic          r_noise;
  logic          w_disagree;

  // Third vote is the live rx sample on the deciding strobe.
  assign w_result   = (r_v0 & r_v1) | (r_v0 & bus.rx) | (r_v1 & bus.rx);
  assign w_disagree = !((r_v0 == r_v1) && (r_v1 == bus.rx));
  assign bus.noise  = r_noise;
`else
  assign w_result   = bus.rx;
  assign bus.noise  = 1'b0;
`endif

  assign w_edge          = bus.baud_en & r_rx_prev & ~bus.rx;
  assign bus.active      = r_active;
  assign bus.center_tick = r_tick;
  assign bus.mid_sample  = r_mid;
  assign bus.false_start = r_false;

  // Phase tracking FSM with registered decision outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_ph         <= '0;
      r_rx_prev    <= 1'b1;
      r_start_pend <= 1'b0;
      r_active     <= 1'b0;
      r_tick       <= 1'b0;
      r_mid        <= 1'b1;
      r_false      <= 1'b0;
`ifdef UART_MAJORITY_VOTE_EN
      r_v0         <= 1'b1;
      r_v1         <= 1'b1;
      r_noise      <= 1'b0;
`endif
    end else begin
      r_tick  <= 1'b0;
      r_false <= 1'b0;
`ifdef UART_MAJORITY_VOTE_EN
      r_noise <= 1'b0;
`endif
      // Edge history runs in both states so a stop/edge collision still
      // leaves rx_prev coherent for the next start bit.
      if (bus.baud_en) begin
        r_rx_prev <= bus.rx;
      end

      case (r_state)
        ST_IDLE: begin
          r_ph <= '0;
          if (w_edge) begin
            // The edge strobe itself is phase 0.
            r_state      <= ST_RUN;
            r_active     <= 1'b1;
            r_ph         <= PW'(1);
            r_start_pend <= 1'b1;
          end
        end

        ST_RUN: begin
          if (bus.stop) begin
            // Any decision on this cycle is dropped.
            r_state  <= ST_IDLE;
            r_active <= 1'b0;
            r_ph     <= '0;
          end else if (bus.baud_en) begin
            r_ph <= (r_ph == c_PH_LAST) ? '0 : r_ph + PW'(1);
`ifdef UART_MAJORITY_VOTE_EN
            if (r_ph == c_PH_V0) r_v0 <= bus.rx;
            if (r_ph == c_PH_V1) r_v1 <= bus.rx;
`endif
            if (r_ph == c_PH_DEC) begin
`ifdef UART_MAJORITY_VOTE_EN
              r_noise <= w_disagree;
`endif
              if (r_start_pend) begin
                if (w_result) begin
                  r_false  <= 1'b1;
                  r_state  <= ST_IDLE;
                  r_active <= 1'b0;
                  r_ph     <= '0;
                end else begin
                  r_start_pend <= 1'b0;
                end
              end else begin
                r_mid  <= w_result;
                r_tick <= 1'b1;
              end
            end
          end
        end

        default: begin
          r_state  <= ST_IDLE;
          r_active <= 1'b0;
          r_ph     <= '0;
        end
      endcase
    end
  end

endmodule : uart_bit_sampler
`default_nettype wire

// File: tb/tb_uart_bit_sampler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_uart_bit_sampler
//  Purpose  : Self-checking bench for uart_bit_sampler. The rx line is
//             described as one level per baud_en strobe; a reference model
//             derives the expected decisions from that waveform.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_bit_sampler;

  localparam int OS     = 16;
  localparam int CENTER = OS / 2;
`ifdef UART_MAJORITY_VOTE_EN
  localparam bit VOTE = 1'b1;
`else
  localparam bit VOTE = 1'b0;
`endif
  localparam int DEC  = VOTE ? CENTER + 1 : CENTER;
  localparam int MAXS = 1024;

  typedef struct packed {
    logic [15:0] idx;
    logic        tick;
    logic        fs;
    logic        nz;
    logic        val;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_bit_sampler_if bus();

  uart_bit_sampler #(.OVERSAMPLE(OS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  ev_t    obs[$];
  ev_t    exp_q[$];
  longint obs_cyc[$];
  longint cyc = 0;
  logic   wave[MAXS];
  logic   stp[MAXS];
  int     n_vec = 0;
  int     n_err = 0;
  int     period = 4;
  int     cur_idx = 0;
  int     samp_idx = 0;

  function automatic ev_t mk_ev(input int idx, input logic t, input logic f,
                                input logic n, input logic v);
    ev_t e;
    e.idx  = idx[15:0];
    e.tick = t;
    e.fs   = f;
    e.nz   = n;
    e.val  = v;
    return e;
  endfunction

  // Remember which strobe the DUT saw last, then log its output pulses.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.baud_en) samp_idx <= cur_idx;
  end

  always @(negedge clk) begin
    if (!rst && (bus.center_tick || bus.false_start || bus.noise)) begin
      obs.push_back(mk_ev(samp_idx, bus.center_tick, bus.false_start, bus.noise,
                          bus.center_tick ? bus.mid_sample : 1'b0));
      if (bus.center_tick) obs_cyc.push_back(cyc);
    end
  end

  task automatic clear_wave();
    for (int i = 0; i < MAXS; i++) begin
      wave[i] = 1'b1;
      stp[i]  = 1'b0;
    end
  endtask

  // Start bit, 8 data bits LSB first, stop bit; OS strobes each.
  task automatic put_frame(input int s, input logic [7:0] b);
    logic v;
    for (int k = 0; k < 10; k++) begin
      v = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
      for (int p = 0; p < OS; p++) wave[s + k*OS + p] = v;
    end
  endtask

  task automatic drive(input int n);
    obs.delete();
    obs_cyc.delete();
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      cur_idx     = i;
      bus.baud_en = 1'b1;
      bus.rx      = wave[i];
      bus.stop    = stp[i];
      for (int p = 1; p < period; p++) begin
        @(posedge clk); #1;
        bus.baud_en = 1'b0;
        bus.stop    = 1'b0;
      end
    end
    @(posedge clk); #1;
    bus.baud_en = 1'b0;
    bus.stop    = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_stop();
    @(posedge clk); #1 bus.stop = 1'b1;
    @(posedge clk); #1 bus.stop = 1'b0;
    @(negedge clk);
  endtask

  // Reference: scan the strobe waveform for falling edges; a locked frame
  // decides bit k from the samples around strobe e + k*OS + CENTER.
  task automatic model(input int n);
    int i, e, j, k, base, d;
    logic prev, r, nz, a, b, c;
    bit stopped;
    exp_q.delete();
    i = 0;
    while (i < n) begin
      prev = (i == 0) ? 1'b1 : wave[i-1];
      if (prev && !wave[i]) begin
        e = i; j = e + 1; k = 0; i = n;
        while (1) begin
          base = e + k*OS;
          d = base + DEC;
          stopped = 0;
          while (j <= d && j < n) begin
            if (stp[j]) begin stopped = 1; break; end
            j++;
          end
          if (stopped) begin i = j + 1; break; end
          if (d >= n) break;
          a = wave[base + CENTER - 1];
          b = wave[base + CENTER];
          c = wave[base + CENTER + 1];
          if (VOTE) begin
            r  = (a + b + c) >= 2;
            nz = !((a == b) && (b == c));
          end else begin
            r  = b;
            nz = 1'b0;
          end
          if (k == 0) begin
            if (r) begin
              exp_q.push_back(mk_ev(d, 1'b0, 1'b1, nz, 1'b0));
              i = d + 1;
              break;
            end else if (nz) begin
              exp_q.push_back(mk_ev(d, 1'b0, 1'b0, 1'b1, 1'b0));
            end
          end else begin
            exp_q.push_back(mk_ev(d, 1'b1, 1'b0, nz, r));
          end
          k++;
        end
      end else begin
        i++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++; if (bus.active !== 1'b0)      begin n_err++; $display("FAIL reset active: got %b want 0", bus.active); end
    n_vec++; if (bus.center_tick !== 1'b0) begin n_err++; $display("FAIL reset center_tick: got %b want 0", bus.center_tick); end
    n_vec++; if (bus.mid_sample !== 1'b1)  begin n_err++; $display("FAIL reset mid_sample: got %b want 1", bus.mid_sample); end
    n_vec++; if (bus.false_start !== 1'b0) begin n_err++; $display("FAIL reset false_start: got %b want 0", bus.false_start); end
    n_vec++; if (bus.noise !== 1'b0)       begin n_err++; $display("FAIL reset noise: got %b want 0", bus.noise); end
    rst = 1'b0;
    clear_wave();
    drive(100);
    n_vec++; if (obs.size() != 0)          begin n_err++; $display("FAIL idle pulses: got %0d want 0", obs.size()); end
    n_vec++; if (bus.mid_sample !== 1'b1)  begin n_err++; $display("FAIL idle mid_sample: got %b want 1", bus.mid_sample); end
    n_vec++; if (bus.active !== 1'b0)      begin n_err++; $display("FAIL idle active: got %b want 0", bus.active); end
  endtask

  task automatic test_frame_55();
    int n;
    period = 4;
    clear_wave();
    put_frame(3, 8'h55);
    stp[3 + 9*OS + DEC + 1] = 1'b1;
    n = 3 + 10*OS + 4;
    drive(n);
    model(n);
    n_vec++; if (obs.size() != exp_q.size()) begin n_err++; $display("FAIL f55 events: got %0d want %0d", obs.size(), exp_q.size()); end
    foreach (exp_q[q]) if (q < obs.size()) begin
      n_vec++; if (obs[q] !== exp_q[q]) begin n_err++; $display("FAIL f55 event %0d: got %h want %h", q, obs[q], exp_q[q]); end
    end
    n_vec++; if (obs_cyc.size() != 9) begin n_err++; $display("FAIL f55 ticks: got %0d want 9", obs_cyc.size()); end
    for (int q = 1; q < obs_cyc.size(); q++) begin
      n_vec++; if (obs_cyc[q] - obs_cyc[q-1] != 64) begin n_err++; $display("FAIL f55 spacing %0d: got %0d want 64", q, obs_cyc[q] - obs_cyc[q-1]); end
    end
    n_vec++; if (bus.active !== 1'b0) begin n_err++; $display("FAIL f55 active: got %b want 0", bus.active); end
  endtask

  task automatic test_glitch();
    int n;
    period = 4;
    clear_wave();
    put_frame(3, 8'hAA);
    wave[3 + OS + CENTER] = 1'b1;
    stp[3 + 9*OS + DEC + 1] = 1'b1;
    n = 3 + 10*OS + 4;
    drive(n);
    model(n);
    n_vec++; if (obs.size() != exp_q.size()) begin n_err++; $display("FAIL glitch events: got %0d want %0d", obs.size(), exp_q.size()); end
    foreach (exp_q[q]) if (q < obs.size()) begin
      n_vec++; if (obs[q] !== exp_q[q]) begin n_err++; $display("FAIL glitch event %0d: got %h want %h", q, obs[q], exp_q[q]); end
    end
    n_vec++;
    if (obs.size() == 0) begin
      n_err++; $display("FAIL glitch bit0: got no tick want one");
    end else if (obs[0].tick !== 1'b1 || obs[0].val !== !VOTE || obs[0].nz !== VOTE) begin
      n_err++; $display("FAIL glitch bit0: got tick=%b val=%b noise=%b want tick=1 val=%b noise=%b",
                        obs[0].tick, obs[0].val, obs[0].nz, !VOTE, VOTE);
    end
  endtask

  task automatic test_false_start();
    int nf, nt;
    period = 2;
    clear_wave();
    for (int i = 5; i < 8; i++) wave[i] = 1'b0;
    drive(60);
    model(60);
    n_vec++; if (obs.size() != exp_q.size()) begin n_err++; $display("FAIL fstart events: got %0d want %0d", obs.size(), exp_q.size()); end
    foreach (exp_q[q]) if (q < obs.size()) begin
      n_vec++; if (obs[q] !== exp_q[q]) begin n_err++; $display("FAIL fstart event %0d: got %h want %h", q, obs[q], exp_q[q]); end
    end
    nf = 0; nt = 0;
    foreach (obs[q]) begin
      if (obs[q].fs) nf++;
      if (obs[q].tick) nt++;
    end
    n_vec++; if (nf != 1) begin n_err++; $display("FAIL fstart pulses: got %0d want 1", nf); end
    n_vec++; if (nt != 0) begin n_err++; $display("FAIL fstart ticks: got %0d want 0", nt); end
    n_vec++; if (bus.active !== 1'b0) begin n_err++; $display("FAIL fstart active: got %b want 0", bus.active); end
  endtask

  task automatic test_stop_decision();
    int n, s, b, nt;
    period = 3;
    clear_wave();
    put_frame(2, 8'h0F);
    s = 2 + 3*OS + DEC;
    stp[s] = 1'b1;
    for (int i = s + 1; i < 2 + 10*OS; i++) wave[i] = 1'b1;
    b = 2 + 10*OS + 5;
    put_frame(b, 8'hC6);
    stp[b + 9*OS + DEC + 1] = 1'b1;
    n = b + 10*OS + 4;
    drive(n);
    model(n);
    n_vec++; if (obs.size() != exp_q.size()) begin n_err++; $display("FAIL stopdec events: got %0d want %0d", obs.size(), exp_q.size()); end
    foreach (exp_q[q]) if (q < obs.size()) begin
      n_vec++; if (obs[q] !== exp_q[q]) begin n_err++; $display("FAIL stopdec event %0d: got %h want %h", q, obs[q], exp_q[q]); end
    end
    nt = 0;
    foreach (obs[q]) if (obs[q].tick) nt++;
    n_vec++; if (nt != 11) begin n_err++; $display("FAIL stopdec ticks: got %0d want 11", nt); end
    n_vec++; if (bus.active !== 1'b0) begin n_err++; $display("FAIL stopdec active: got %b want 0", bus.active); end
  endtask

  task automatic test_rst_mid();
    int n, nt;
    period = 4;
    clear_wave();
    put_frame(2, 8'h00);
    n = 2 + 5*OS + CENTER;
    drive(n);
    model(n);
    n_vec++; if (obs.size() != exp_q.size()) begin n_err++; $display("FAIL rstmid events: got %0d want %0d", obs.size(), exp_q.size()); end
    foreach (exp_q[q]) if (q < obs.size()) begin
      n_vec++; if (obs[q] !== exp_q[q]) begin n_err++; $display("FAIL rstmid event %0d: got %h want %h", q, obs[q], exp_q[q]); end
    end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_vec++; if (bus.active !== 1'b0)      begin n_err++; $display("FAIL rstmid active: got %b want 0", bus.active); end
    n_vec++; if (bus.center_tick !== 1'b0) begin n_err++; $display("FAIL rstmid center_tick: got %b want 0", bus.center_tick); end
    n_vec++; if (bus.mid_sample !== 1'b1)  begin n_err++; $display("FAIL rstmid mid_sample: got %b want 1", bus.mid_sample); end
    n_vec++; if (bus.false_start !== 1'b0) begin n_err++; $display("FAIL rstmid false_start: got %b want 0", bus.false_start); end
    n_vec++; if (bus.noise !== 1'b0)       begin n_err++; $display("FAIL rstmid noise: got %b want 0", bus.noise); end
    rst = 1'b0;
    clear_wave();
    put_frame(2, 8'hA3);
    stp[2 + 9*OS + DEC + 1] = 1'b1;
    n = 2 + 10*OS + 4;
    drive(n);
    model(n);
    n_vec++; if (obs.size() != exp_q.size()) begin n_err++; $display("FAIL a3 events: got %0d want %0d", obs.size(), exp_q.size()); end
    foreach (exp_q[q]) if (q < obs.size()) begin
      n_vec++; if (obs[q] !== exp_q[q]) begin n_err++; $display("FAIL a3 event %0d: got %h want %h", q, obs[q], exp_q[q]); end
    end
    nt = 0;
    foreach (obs[q]) if (obs[q].tick) nt++;
    n_vec++; if (nt != 9) begin n_err++; $display("FAIL a3 ticks: got %0d want 9", nt); end
  endtask

  task automatic test_random();
    int pos, n;
    for (int it = 0; it < 12; it++) begin
      period = $urandom_range(1, 4);
      clear_wave();
      pos = $urandom_range(1, 6);
      for (int f = 0; f < 3; f++) begin
        put_frame(pos, 8'($urandom));
        if ($urandom_range(0, 2) == 0) begin
          n = pos + $urandom_range(0, 10*OS - 1);
          wave[n] = !wave[n];
        end
        stp[pos + 9*OS + DEC + $urandom_range(1, OS - DEC - 1)] = 1'b1;
        pos = pos + 10*OS + $urandom_range(0, 5);
      end
      n = pos + 4;
      drive(n);
      model(n);
      n_vec++; if (obs.size() != exp_q.size()) begin n_err++; $display("FAIL rand%0d events: got %0d want %0d", it, obs.size(), exp_q.size()); end
      foreach (exp_q[q]) if (q < obs.size()) begin
        n_vec++; if (obs[q] !== exp_q[q]) begin n_err++; $display("FAIL rand%0d event %0d: got %h want %h", it, q, obs[q], exp_q[q]); end
      end
      pulse_stop();
    end
  endtask

  initial begin
    rst         = 1'b1;
    bus.baud_en = 1'b0;
    bus.rx      = 1'b1;
    bus.stop    = 1'b0;
    test_reset();
    test_frame_55();
    test_glitch();
    test_false_start();
    test_stop_decision();
    test_rst_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule : tb_uart_bit_sampler
`default_nettype wire

// File: doc/uart_bit_sampler.md
# uart_bit_sampler

Oversampled bit-phase tracker and sampler for the UART receive path. It locks phase to the start-bit falling edge and validates the start bit. It then emits one `center_tick` per bit with a sampled value: a 3-sample majority vote around bit centre, or a single centre sample. It sits between the rx input synchronizer and the UART receive FSM, which consumes `center_tick`/`mid_sample` and ends the frame with `stop`.

## Interface
- `OVERSAMPLE`, 16: `baud_en` ticks per bit. Must be ≥ 4; otherwise elaboration fails with `$error`.
- Derived: `CENTER = OVERSAMPLE/2` (integer division); counter width `$clog2(OVERSAMPLE)`.
- `clk`  input  1  sole clock.
- `rst`  input  1  synchronous, active-high reset.
- `baud_en`  input  1  oversample strobe, one `clk` wide.
- `rx`  input  1  serial line, already synchronized to `clk`; idle high.
- `stop`  input  1  receive-FSM request to end the frame and return to IDLE.
- `active`  output  1  high while in RUN.
- `center_tick`  output  1  one-`clk` pulse: a data/stop bit decision is valid.
- `mid_sample`  output  1  decided bit value; held until the next decision.
- `false_start`  output  1  one-`clk` pulse: the start bit was rejected.
- `noise`  output  1  one-`clk` pulse: the three votes disagreed (macro builds only; tied 0 otherwise).

## Operation
- States: IDLE and RUN. Reset enters IDLE.
- The phase counter `ph` advances only on `baud_en`.
- `rx_prev` registers `rx` on every `baud_en` in both states. It resets to 1.
- Edge detection:
  - An edge is `baud_en && rx_prev && !rx`.
  - IDLE → RUN on an edge. At the same time `ph ← 1`, so the edge sample is phase 0.
  - `ph` is held at 0 while in IDLE.
- In RUN, each `baud_en` does `ph ← ph+1`, wrapping from `OVERSAMPLE-1` to 0.
- Edges seen during RUN are ignored; there is no mid-frame resync.
- Decision point:
  - The decision is taken on the `baud_en` where `ph == CENTER+1` (vote mode) or `ph == CENTER` (single mode).
  - Vote samples are `rx` at `ph == CENTER-1`, `CENTER` and `CENTER+1`.
  - Result = majority of the three samples, or the single `CENTER` sample.
- Start-bit validation on the first decision after entering RUN:
  - Result 0: start bit accepted. No `center_tick`, and `mid_sample` is unchanged.
  - Result 1: `false_start` pulses, the block returns to IDLE and `ph ← 0`.
- Every later decision: `mid_sample ←` result and `center_tick` pulses.
- The block does not count bits. The FSM asserts `stop` after the stop-bit tick.
- `stop` in RUN:
  - Next state is IDLE and `ph ← 0`.
  - A decision in the same cycle is discarded: no tick, no `noise`, no `false_start`.
- `stop` in IDLE has no effect. An edge in the same cycle is still taken.
- `stop` and an edge in the same cycle while in RUN: `stop` wins and the block ends in IDLE. `rx_prev` still updates.

## Timing
- Reset values:
  - `active` = 0, `center_tick` = 0, `mid_sample` = 1.
  - `false_start` = 0, `noise` = 0.
  - Internal: `ph` = 0, `rx_prev` = 1, state IDLE.
- All outputs are registered.
- `center_tick`, `mid_sample`, `false_start` and `noise` update one `clk` after the deciding `baud_en` cycle.
- `active` rises one `clk` after the edge-detect cycle. It falls one `clk` after `stop` or after the rejecting decision cycle.
- In vote mode, decisions land one oversample period later than in single mode: `CENTER+1` phases after the edge, versus `CENTER`.
- Spacing between `center_tick` pulses is exactly `OVERSAMPLE` `baud_en` strobes.
- Odd `OVERSAMPLE`: `CENTER` rounds down. For 5, `CENTER` = 2 and the votes are at phases 1, 2, 3.
- `rst` mid-frame: all reset values apply on the next `clk`, with no tick emitted.
- `baud_en` held high every `clk` is legal; behaviour is purely strobe-counted.

## Configuration
- `UART_MAJORITY_VOTE_EN` defined:
  - 3-sample majority vote at `CENTER-1..CENTER+1`, decided at `CENTER+1`.
  - `noise` pulses with the decision whenever the three samples are not all equal.
  - `noise` pulses on every decision, including the start bit. A rejected start bit can pulse `noise` and `false_start` together.
- Undefined:
  - Single sample at `CENTER`, decided at `CENTER`.
  - `noise` constant 0, and the vote registers are not built.

## Test plan
- Reset, then idle line (`rx` = 1) for 100 `baud_en` → `active` = 0, `mid_sample` = 1, no pulses on any output.
- `OVERSAMPLE` = 16, `baud_en` every 4 `clk`, frame 0x55 LSB-first with stop bit; FSM asserts `stop` after the 9th tick → 9 ticks spaced 64 `clk`, `mid_sample` sequence 1,0,1,0,1,0,1,0,1, then `active` = 0.
- Macro on: a single-`baud_en`-wide rx glitch to 1 at phase `CENTER` inside data bit 0 of value 0 → tick with `mid_sample` = 0 and `noise` = 1. Macro off, same stimulus → `mid_sample` = 1 and `noise` = 0.
- `rx` low for 3 `baud_en` then high → `false_start` pulses once, no `center_tick`, `active` returns to 0.
- `stop` asserted in the same cycle as a data decision → no `center_tick`; IDLE next `clk`; a new falling edge restarts with `ph` = 1.
- `rst` asserted for one `clk` mid-bit 4 → all outputs at reset values next `clk`; a subsequent 0xA3 frame is received correctly.
